// File: rtl/wr_ptr.sv
// wr_ptr: write-side pointer controller for a single-clock FIFO.
// Accepts upstream valid/ready beats, drives the RAM write address and write
// enable, advances the extended write pointer and keeps a registered ready
// that drops exactly when the FIFO becomes full. Occupancy and almost-full
// are optional.
//
// Optional feature macro: WR_PTR_OCCUPANCY_EN
//   defined     : o_count / o_afull carry registered occupancy and almost-full
//   not defined : o_count / o_afull are tied to 0
//
// Ports:
//   clk        clock
//   rstn       synchronous active-low reset
//   i_tvalid   upstream beat valid
//   o_tready   upstream ready (registered, 1 = not full)
//   o_waddr    RAM write address (low ALEN bits of o_wptr)
//   o_wptr     extended write pointer, MSB is the wrap bit
//   i_rptr     extended read pointer from the read side
//   i_rd_en    read handshake this cycle
//   o_ram_wen  RAM write enable (combinational handshake)
//   o_count    registered occupancy 0..DEPTH
//   o_afull    registered almost-full
module wr_ptr #(
   parameter int unsigned ALEN         = 8,
   parameter int unsigned INCR         = 1,
   parameter int unsigned AFULL_THRESH = (1 << ALEN) - 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_tvalid,
   output logic            o_tready,
   output logic [ALEN-1:0] o_waddr,
   output logic [ALEN:0]   o_wptr,
   input  logic [ALEN:0]   i_rptr,
   input  logic            i_rd_en,
   output logic            o_ram_wen,
   output logic [ALEN:0]   o_count,
   output logic            o_afull
);

   localparam int unsigned DEPTH = 1 << ALEN;
   localparam int unsigned PW    = ALEN + 1;

   // Elaboration-time parameter sanity checks
   generate
      if ((INCR == 0) || ((INCR & (INCR - 1)) != 0) || (INCR > DEPTH)) begin : g_bad_incr
         $error("wr_ptr: INCR must be a power of two no larger than DEPTH");
      end
      if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_thresh
         $error("wr_ptr: AFULL_THRESH must be in 1..DEPTH");
      end
   endgenerate

   logic [PW-1:0] wptr_d;
   logic [PW-1:0] rptr_d;
   logic [PW-1:0] occ_d;
   logic          full_d;

   // Handshake: ready is registered, so the write enable never loops back
   assign o_ram_wen = i_tvalid & o_tready;
   assign o_waddr   = o_wptr[ALEN-1:0];

   // Next-pointer look-ahead for both sides so full tracks the same edge
   always_comb begin
      wptr_d = o_wptr;
      rptr_d = i_rptr;
      if (o_ram_wen) begin
         wptr_d = o_wptr + PW'(INCR);
      end
      if (i_rd_en) begin
         rptr_d = i_rptr + PW'(INCR);
      end
      occ_d  = wptr_d - rptr_d;
      full_d = (occ_d == PW'(DEPTH));
   end

   // Pointer and ready registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_wptr   <= '0;
         o_tready <= 1'b0;
      end else begin
         o_wptr   <= wptr_d;
         o_tready <= ~full_d;
      end
   end

`ifdef WR_PTR_OCCUPANCY_EN
   // Occupancy and almost-full, registered from the same look-ahead
   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_count <= '0;
         o_afull <= 1'b0;
      end else begin
         o_count <= occ_d;
         o_afull <= (occ_d >= PW'(AFULL_THRESH));
      end
   end
`else
   assign o_count = '0;
   assign o_afull = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ptr.sv
// tb_wr_ptr: directed table-driven bench for wr_ptr with ALEN=3, INCR=1,
// AFULL_THRESH=6. Expectations for o_count/o_afull follow WR_PTR_OCCUPANCY_EN.
module tb_wr_ptr;

   localparam int unsigned ALEN = 3;

`ifdef WR_PTR_OCCUPANCY_EN
   localparam bit OCC = 1'b1;
`else
   localparam bit OCC = 1'b0;
`endif

   logic            clk;
   logic            rstn;
   logic            i_tvalid;
   logic            o_tready;
   logic [ALEN-1:0] o_waddr;
   logic [ALEN:0]   o_wptr;
   logic [ALEN:0]   i_rptr;
   logic            i_rd_en;
   logic            o_ram_wen;
   logic [ALEN:0]   o_count;
   logic            o_afull;

   int n_checks;
   int n_fail;
   logic [ALEN:0] rptr;

   wr_ptr #(.ALEN(ALEN), .INCR(1), .AFULL_THRESH(6)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .i_tvalid (i_tvalid),
      .o_tready (o_tready),
      .o_waddr  (o_waddr),
      .o_wptr   (o_wptr),
      .i_rptr   (i_rptr),
      .i_rd_en  (i_rd_en),
      .o_ram_wen(o_ram_wen),
      .o_count  (o_count),
      .o_afull  (o_afull)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       tv;
      logic       rd;
      logic       wen;
      logic [2:0] waddr;
      logic [3:0] wptr;
      logic       rdy;
      int         cnt;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, check comb outputs, then registered ones
   task automatic step(input logic tv, input logic rd, input logic wen,
                       input logic [2:0] waddr, input logic [3:0] wptr,
                       input logic rdy, input int cnt);
      i_tvalid = tv;
      i_rd_en  = rd;
      i_rptr   = rptr;
      #1;
      check("ram_wen", int'(o_ram_wen), int'(wen));
      check("waddr", int'(o_waddr), int'(waddr));
      @(posedge clk);
      #1;
      if (rd) rptr = rptr + 4'd1;
      check("wptr", int'(o_wptr), int'(wptr));
      check("tready", int'(o_tready), int'(rdy));
      check("count", int'(o_count), OCC ? cnt : 0);
      check("afull", int'(o_afull), (OCC && cnt >= 6) ? 1 : 0);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] w;
      n_checks = 0;
      n_fail   = 0;
      rptr     = '0;

      // Fill: 8 writes at waddr 0..7, ready drops after the 8th
      for (int k = 0; k < 8; k++) begin
         tbl[k] = '{1'b1, 1'b0, 1'b1, 3'(k), 4'(k + 1), (k < 7), k + 1};
      end
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd8, 1'b0, 8};  // full: no write
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 4'd8, 1'b1, 7};  // read frees a slot
      tbl[10] = '{1'b1, 1'b0, 1'b1, 3'd0, 4'd9, 1'b0, 8};  // refill at waddr 0
      tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd1, 4'd9, 1'b1, 7};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 3'd1, 4'd9, 1'b1, 6};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 3'd1, 4'd9, 1'b1, 5};  // afull drops 6->5
      tbl[14] = '{1'b0, 1'b1, 1'b0, 3'd1, 4'd9, 1'b1, 4};

      // Reset held with tvalid high
      rstn     = 1'b0;
      i_tvalid = 1'b1;
      i_rd_en  = 1'b0;
      i_rptr   = '0;
      @(negedge clk);
      @(posedge clk);
      #1;
      check("rst_tready", int'(o_tready), 0);
      check("rst_wen", int'(o_ram_wen), 0);
      check("rst_wptr", int'(o_wptr), 0);
      check("rst_count", int'(o_count), 0);
      check("rst_afull", int'(o_afull), 0);
      @(negedge clk);

      // Release: no write in the first cycle, ready rises after the edge
      rstn = 1'b1;
      step(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 0);

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].tv, tbl[i].rd, tbl[i].wen, tbl[i].waddr,
              tbl[i].wptr, tbl[i].rdy, tbl[i].cnt);
      end

      // Streaming at occupancy 4: write and read each cycle, wptr wraps 15->0
      w = 4'd9;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b1, w[2:0], w + 4'd1, 1'b1, 4);
         w = w + 4'd1;
      end
      check("wrap_wptr", int'(o_wptr), 13);

      // One more write to occupancy 5, then reset mid-burst
      step(1'b1, 1'b0, 1'b1, 3'd5, 4'd14, 1'b1, 5);
      rstn     = 1'b0;
      i_tvalid = 1'b1;
      i_rd_en  = 1'b0;
      @(posedge clk);
      #1;
      rptr = '0;
      check("mid_rst_wptr", int'(o_wptr), 0);
      check("mid_rst_tready", int'(o_tready), 0);
      check("mid_rst_count", int'(o_count), 0);
      check("mid_rst_afull", int'(o_afull), 0);
      check("mid_rst_wen", int'(o_ram_wen), 0);
      @(negedge clk);
      rstn = 1'b1;
      step(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 0);
      step(1'b1, 1'b0, 1'b1, 3'd0, 4'd1, 1'b1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
